// File: rtl/projectile_pool.sv
// projectile_pool: a fixed set of projectile slots. Each slot moves horizontally
// on game ticks. New projectiles arrive through a valid/ready spawn port. A slot
// is retired when it leaves the playfield (escaped pulse) or when it is hit.
// Slot state is flattened onto wide buses for the graphics generator.
module projectile_pool #(
  parameter int NUM_SLOTS = 3,
  parameter int X_W       = 4,
  parameter int Y_W       = 4,
  parameter int COLOR_W   = 12,
  parameter int X_MAX     = 15,
  parameter int STEP      = 1,
  parameter int SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  parameter int CW        = $clog2(NUM_SLOTS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         freeze,
  input  logic                         spawn_valid,
  output logic                         spawn_ready,
  input  logic [Y_W-1:0]               spawn_y,
  input  logic [COLOR_W-1:0]           spawn_color,
  input  logic                         hit_valid,
  input  logic [SW-1:0]                hit_slot,
  output logic [NUM_SLOTS-1:0]         active,
  output logic [NUM_SLOTS*X_W-1:0]     slot_x,
  output logic [NUM_SLOTS*Y_W-1:0]     slot_y,
  output logic [NUM_SLOTS*COLOR_W-1:0] slot_color,
  output logic [NUM_SLOTS-1:0]         escaped,
  output logic [CW-1:0]                count
);

  typedef enum logic {FREE = 1'b0, FLYING = 1'b1} slot_state_t;

  slot_state_t          state_q [NUM_SLOTS];
  slot_state_t          state_d [NUM_SLOTS];
  logic [X_W-1:0]       x_q     [NUM_SLOTS];
  logic [X_W-1:0]       x_d     [NUM_SLOTS];
  logic [Y_W-1:0]       y_q     [NUM_SLOTS];
  logic [Y_W-1:0]       y_d     [NUM_SLOTS];
  logic [COLOR_W-1:0]   color_q [NUM_SLOTS];
  logic [COLOR_W-1:0]   color_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] escaped_d;
  logic [NUM_SLOTS-1:0] spawn_sel;
  logic [CW-1:0]        count_d;
  logic                 spawn_fire;
  logic                 move;
  logic                 found;

  // Present registered slot state on the flattened output buses.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign active[g]                         = (state_q[g] == FLYING);
    assign slot_x[g*X_W +: X_W]              = x_q[g];
    assign slot_y[g*Y_W +: Y_W]              = y_q[g];
    assign slot_color[g*COLOR_W +: COLOR_W]  = color_q[g];
  end

  // Ready depends only on registered occupancy and freeze, never on a same-cycle hit,
  // so a slot freed by a hit cannot be reused in the cycle it is freed.
  assign spawn_ready = ~freeze & ~(&active);
  assign spawn_fire  = spawn_valid & spawn_ready;
  assign move        = tick & ~freeze;

  // Pick the lowest-index free slot for an accepted spawn.
  always_comb begin
    spawn_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found && state_q[i] == FREE) begin
        spawn_sel[i] = spawn_fire;
        found        = 1'b1;
      end
    end
  end

  // Per-slot next state: spawn load, then hit clear, then tick advance or exit.
  always_comb begin
    escaped_d = '0;
    count_d   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      color_d[i] = color_q[i];
      if (spawn_sel[i]) begin
        state_d[i] = FLYING;
        x_d[i]     = '0;
        y_d[i]     = spawn_y;
        color_d[i] = spawn_color;
      end else if (hit_valid && hit_slot == SW'(i) && state_q[i] == FLYING) begin
        state_d[i] = FREE;
      end else if (move && state_q[i] == FLYING) begin
        if (({1'b0, x_q[i]} + (X_W+1)'(STEP)) > (X_W+1)'(X_MAX)) begin
          state_d[i]   = FREE;
          escaped_d[i] = 1'b1;
        end else begin
          x_d[i] = x_q[i] + X_W'(STEP);
        end
      end
      count_d = count_d + CW'(state_d[i] == FLYING);
    end
  end

  // Slot registers, escape pulses and occupancy count; reset discards every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= FREE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        color_q[i] <= '0;
      end
      escaped <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        color_q[i] <= color_d[i];
      end
      escaped <= escaped_d;
      count   <= count_d;
    end
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Testbench for projectile_pool: directed scenarios plus a randomized run
// compared against a slot-list reference model.
module tb_projectile_pool;

  localparam int NS   = 3;
  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int COLW = 12;
  localparam int XMAX = 15;
  localparam int STEP = 1;
  localparam int SW   = 2;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick = 1'b0;
  logic              freeze = 1'b0;
  logic              spawn_valid = 1'b0;
  logic              spawn_ready;
  logic [YW-1:0]     spawn_y = '0;
  logic [COLW-1:0]   spawn_color = '0;
  logic              hit_valid = 1'b0;
  logic [SW-1:0]     hit_slot = '0;
  logic [NS-1:0]     active;
  logic [NS*XW-1:0]  slot_x;
  logic [NS*YW-1:0]  slot_y;
  logic [NS*COLW-1:0] slot_color;
  logic [NS-1:0]     escaped;
  logic [CW-1:0]     count;

  int checks = 0;
  int errors = 0;

  bit m_act [NS];
  bit m_esc [NS];
  int m_x   [NS];
  int m_y   [NS];
  int m_col [NS];

  projectile_pool #(
    .NUM_SLOTS(NS), .X_W(XW), .Y_W(YW), .COLOR_W(COLW), .X_MAX(XMAX), .STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .freeze(freeze),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_y(spawn_y), .spawn_color(spawn_color),
    .hit_valid(hit_valid), .hit_slot(hit_slot),
    .active(active), .slot_x(slot_x), .slot_y(slot_y), .slot_color(slot_color),
    .escaped(escaped), .count(count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_esc[i] = 0; m_x[i] = 0; m_y[i] = 0; m_col[i] = 0;
    end
  endtask

  function automatic bit m_ready();
    int n = 0;
    for (int i = 0; i < NS; i++) n += int'(m_act[i]);
    return !freeze && (n < NS);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NS; i++) n += int'(m_act[i]);
    return n;
  endfunction

  // Apply the game rules to the model for the inputs currently driven.
  task automatic model_step();
    int tgt = -1;
    if (spawn_valid && m_ready()) begin
      for (int i = NS - 1; i >= 0; i--) if (!m_act[i]) tgt = i;
    end
    for (int i = 0; i < NS; i++) begin
      m_esc[i] = 0;
      if (i == tgt) begin
        m_act[i] = 1; m_x[i] = 0; m_y[i] = int'(spawn_y); m_col[i] = int'(spawn_color);
      end else if (hit_valid && int'(hit_slot) == i && m_act[i]) begin
        m_act[i] = 0;
      end else if (m_act[i] && tick && !freeze) begin
        if (m_x[i] + STEP > XMAX) begin
          m_act[i] = 0; m_esc[i] = 1;
        end else begin
          m_x[i] = m_x[i] + STEP;
        end
      end
    end
  endtask

  function automatic logic [NS-1:0] exp_active();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [NS-1:0] exp_escaped();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_esc[i];
    return v;
  endfunction

  function automatic logic [NS*XW-1:0] exp_x();
    logic [NS*XW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*XW +: XW] = XW'(m_x[i]);
    return v;
  endfunction

  function automatic logic [NS*YW-1:0] exp_y();
    logic [NS*YW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*YW +: YW] = YW'(m_y[i]);
    return v;
  endfunction

  function automatic logic [NS*COLW-1:0] exp_col();
    logic [NS*COLW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*COLW +: COLW] = COLW'(m_col[i]);
    return v;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick = 0; freeze = 0; spawn_valid = 0; hit_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #1;
    rst = 1;
    model_reset();
    #2;
    checks++; if (active !== 3'b000) begin errors++; $display("[TB] FAIL reset_active got %b want 000", active); end
    checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (escaped !== 3'b000) begin errors++; $display("[TB] FAIL reset_escaped got %b want 000", escaped); end
    checks++; if (slot_x !== '0 || slot_y !== '0 || slot_color !== '0) begin errors++; $display("[TB] FAIL reset_slots got x=%h y=%h c=%h want 0", slot_x, slot_y, slot_color); end
    checks++; if (spawn_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", spawn_ready); end
    freeze = 1;
    #1;
    checks++; if (spawn_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_freeze got %b want 0", spawn_ready); end
    freeze = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_single_spawn();
    do_reset();
    spawn_valid = 1; spawn_y = 4'd5; spawn_color = 12'hF00;
    cycle();
    spawn_valid = 0;
    checks++; if (active !== 3'b001) begin errors++; $display("[TB] FAIL spawn_active got %b want 001", active); end
    checks++; if (slot_x[3:0] !== 4'd0) begin errors++; $display("[TB] FAIL spawn_x got %0d want 0", slot_x[3:0]); end
    checks++; if (slot_y[3:0] !== 4'd5) begin errors++; $display("[TB] FAIL spawn_y got %0d want 5", slot_y[3:0]); end
    checks++; if (slot_color[11:0] !== 12'hF00) begin errors++; $display("[TB] FAIL spawn_color got %h want F00", slot_color[11:0]); end
    checks++; if (count !== 2'd1) begin errors++; $display("[TB] FAIL spawn_count got %0d want 1", count); end
  endtask

  task automatic test_back_to_back();
    logic [NS-1:0] want;
    do_reset();
    spawn_valid = 1;
    for (int k = 0; k < 3; k++) begin
      spawn_y = YW'(k + 1); spawn_color = COLW'(12'h0A0 + k);
      cycle();
      want = NS'((1 << (k + 1)) - 1);
      checks++; if (active !== want) begin errors++; $display("[TB] FAIL b2b_active%0d got %b want %b", k, active, want); end
    end
    spawn_y = 4'd7; spawn_color = 12'h777;
    checks++; if (spawn_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %b want 0", spawn_ready); end
    repeat (3) cycle();
    checks++; if (slot_y !== 12'h321 || count !== 2'd3) begin errors++; $display("[TB] FAIL stall_hold got y=%h cnt=%0d want y=321 cnt=3", slot_y, count); end
    hit_valid = 1; hit_slot = 2'd1;
    cycle();
    hit_valid = 0;
    checks++; if (active !== 3'b101) begin errors++; $display("[TB] FAIL hit_active got %b want 101", active); end
    checks++; if (spawn_ready !== 1'b1) begin errors++; $display("[TB] FAIL hit_ready got %b want 1", spawn_ready); end
    cycle();
    spawn_valid = 0;
    checks++; if (active !== 3'b111 || slot_y !== 12'h371) begin errors++; $display("[TB] FAIL refill got act=%b y=%h want 111 371", active, slot_y); end
    checks++; if (slot_color[23:12] !== 12'h777) begin errors++; $display("[TB] FAIL refill_color got %h want 777", slot_color[23:12]); end
  endtask

  task automatic test_escape();
    do_reset();
    spawn_valid = 1; spawn_y = 4'd2; spawn_color = 12'hABC;
    cycle();
    spawn_valid = 0; tick = 1;
    for (int k = 1; k <= 15; k++) begin
      cycle();
      checks++; if (slot_x[3:0] !== XW'(k) || active !== 3'b001 || escaped !== 3'b000) begin errors++; $display("[TB] FAIL move%0d got x=%0d act=%b esc=%b want x=%0d act=001 esc=000", k, slot_x[3:0], active, escaped, k); end
    end
    cycle();
    tick = 0;
    checks++; if (active !== 3'b000 || escaped !== 3'b001) begin errors++; $display("[TB] FAIL exit got act=%b esc=%b want 000 001", active, escaped); end
    checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL exit_count got %0d want 0", count); end
    cycle();
    checks++; if (escaped !== 3'b000) begin errors++; $display("[TB] FAIL exit_pulse got %b want 000", escaped); end
  endtask

  task automatic test_hit_tick_spawn();
    do_reset();
    spawn_valid = 1; spawn_y = 4'd1; spawn_color = 12'h111;
    cycle();
    spawn_valid = 0; tick = 1;
    repeat (15) cycle();
    hit_valid = 1; hit_slot = 2'd0;
    spawn_valid = 1; spawn_y = 4'd9; spawn_color = 12'h0F0;
    cycle();
    idle_inputs();
    checks++; if (active !== 3'b010 || escaped !== 3'b000) begin errors++; $display("[TB] FAIL combo got act=%b esc=%b want 010 000", active, escaped); end
    checks++; if (slot_x[7:4] !== 4'd0 || slot_y[7:4] !== 4'd9) begin errors++; $display("[TB] FAIL combo_slot1 got x=%0d y=%0d want 0 9", slot_x[7:4], slot_y[7:4]); end
    checks++; if (count !== 2'd1) begin errors++; $display("[TB] FAIL combo_count got %0d want 1", count); end
  endtask

  task automatic test_freeze();
    do_reset();
    spawn_valid = 1; spawn_y = 4'd3; spawn_color = 12'h00F;
    cycle();
    spawn_valid = 0; tick = 1;
    cycle();
    freeze = 1; spawn_valid = 1; spawn_y = 4'd4;
    #1;
    checks++; if (spawn_ready !== 1'b0) begin errors++; $display("[TB] FAIL freeze_ready got %b want 0", spawn_ready); end
    repeat (4) cycle();
    checks++; if (slot_x[3:0] !== 4'd1 || active !== 3'b001) begin errors++; $display("[TB] FAIL freeze_hold got x=%0d act=%b want 1 001", slot_x[3:0], active); end
    freeze = 0; tick = 0;
    #1;
    checks++; if (spawn_ready !== 1'b1) begin errors++; $display("[TB] FAIL unfreeze_ready got %b want 1", spawn_ready); end
    cycle();
    spawn_valid = 0;
    checks++; if (active !== 3'b011) begin errors++; $display("[TB] FAIL unfreeze_spawn got %b want 011", active); end
    tick = 1;
    cycle();
    tick = 0;
    checks++; if (slot_x[7:0] !== 8'h12) begin errors++; $display("[TB] FAIL unfreeze_move got %h want 12", slot_x[7:0]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    spawn_valid = 1; spawn_y = 4'd6; spawn_color = 12'h555;
    cycle(); cycle();
    spawn_valid = 0; tick = 1;
    cycle(); cycle();
    checks++; if (active !== 3'b011) begin errors++; $display("[TB] FAIL pre_reset got %b want 011", active); end
    @(negedge clk);
    #2;
    rst = 1;
    model_reset();
    #1;
    checks++; if (active !== 3'b000 || count !== 2'd0 || escaped !== 3'b000) begin errors++; $display("[TB] FAIL async_reset got act=%b cnt=%0d esc=%b want 0", active, count, escaped); end
    checks++; if (slot_x !== '0 || slot_y !== '0 || slot_color !== '0) begin errors++; $display("[TB] FAIL async_slots got x=%h y=%h c=%h want 0", slot_x, slot_y, slot_color); end
    @(posedge clk);
    #1;
    checks++; if (escaped !== 3'b000) begin errors++; $display("[TB] FAIL async_esc got %b want 000", escaped); end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      tick        = 1'($urandom_range(0, 1));
      freeze      = ($urandom_range(0, 9) == 0);
      spawn_valid = ($urandom_range(0, 2) == 0);
      spawn_y     = YW'($urandom);
      spawn_color = COLW'($urandom);
      hit_valid   = ($urandom_range(0, 3) == 0);
      hit_slot    = SW'($urandom_range(0, 3));
      #1;
      checks++; if (spawn_ready !== m_ready()) begin errors++; $display("[TB] FAIL rnd_ready@%0d got %b want %b", n, spawn_ready, m_ready()); end
      cycle();
      checks++; if (active !== exp_active() || escaped !== exp_escaped()) begin errors++; $display("[TB] FAIL rnd_flags@%0d got act=%b esc=%b want act=%b esc=%b", n, active, escaped, exp_active(), exp_escaped()); end
      checks++; if (slot_x !== exp_x() || slot_y !== exp_y() || slot_color !== exp_col()) begin errors++; $display("[TB] FAIL rnd_slots@%0d got x=%h y=%h c=%h want x=%h y=%h c=%h", n, slot_x, slot_y, slot_color, exp_x(), exp_y(), exp_col()); end
      checks++; if (int'(count) !== m_count()) begin errors++; $display("[TB] FAIL rnd_count@%0d got %0d want %0d", n, count, m_count()); end
    end
    idle_inputs();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_spawn();
    test_back_to_back();
    test_escape();
    test_hit_tick_spawn();
    test_freeze();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
